// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match sequencer for the two-player ping-pong display.
// Ports: clk, reset (sync, high), frame_tick, start, miss_l, miss_r in;
//        play_en, ball_reset, serve_dir, score_l, score_r, game_over,
//        winner, state out (all registered).
module pong_game_ctrl #(
  parameter int POINTS_TO_WIN = 9,
  parameter int SERVE_DELAY   = 60,
  parameter int POINT_DELAY   = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       play_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    POINT = 3'd4,
    OVER  = 3'd5
  } state_t;

  // A zero delay would never expire; treat it as one tick.
  localparam int SD = (SERVE_DELAY == 0) ? 1 : SERVE_DELAY;
  localparam int PD = (POINT_DELAY == 0) ? 1 : POINT_DELAY;
  localparam logic [7:0] SD_LAST = 8'(SD - 1);
  localparam logic [7:0] PD_LAST = 8'(PD - 1);
  localparam logic [3:0] WIN = 4'(POINTS_TO_WIN);

  state_t     cur;
  state_t     nxt;
  logic       start_q;
  logic [7:0] cnt;
  logic [7:0] cnt_d;
  logic       ball_reset_d;
  logic       serve_dir_d;
  logic [3:0] score_l_d;
  logic [3:0] score_r_d;
  logic       winner_d;
  logic       start_rise;

  assign start_rise = start & ~start_q;
  assign state      = cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= IDLE;
      start_q    <= 1'b0;
      cnt        <= 8'd0;
      play_en    <= 1'b0;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b1;
      score_l    <= 4'd0;
      score_r    <= 4'd0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      cur        <= nxt;
      start_q    <= start;
      cnt        <= cnt_d;
      play_en    <= (nxt == PLAY);
      ball_reset <= ball_reset_d;
      serve_dir  <= serve_dir_d;
      score_l    <= score_l_d;
      score_r    <= score_r_d;
      game_over  <= (nxt == OVER);
      winner     <= winner_d;
    end
  end

  always_comb begin
    nxt          = cur;
    cnt_d        = cnt;
    ball_reset_d = 1'b0;
    serve_dir_d  = serve_dir;
    score_l_d    = score_l;
    score_r_d    = score_r;
    winner_d     = winner;
    unique case (cur)
      IDLE: begin
        if (start_rise) begin
          nxt          = SERVE;
          cnt_d        = 8'd0;
          ball_reset_d = 1'b1;
          serve_dir_d  = 1'b1;
          score_l_d    = 4'd0;
          score_r_d    = 4'd0;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt == SD_LAST) begin
            nxt   = PLAY;
            cnt_d = 8'd0;
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end
      end
      PLAY: begin
        // Any miss outranks a pause request in the same cycle.
        if (miss_l && miss_r) begin
          nxt   = POINT;
          cnt_d = 8'd0;
        end else if (miss_l) begin
          nxt         = POINT;
          cnt_d       = 8'd0;
          serve_dir_d = 1'b0;
          if (score_r != WIN) score_r_d = score_r + 4'd1;
        end else if (miss_r) begin
          nxt         = POINT;
          cnt_d       = 8'd0;
          serve_dir_d = 1'b1;
          if (score_l != WIN) score_l_d = score_l + 4'd1;
        end else if (start_rise) begin
          nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (start_rise) nxt = PLAY;
      end
      POINT: begin
        if (frame_tick) begin
          if (cnt == PD_LAST) begin
            cnt_d = 8'd0;
            if (score_l == WIN || score_r == WIN) begin
              nxt      = OVER;
              winner_d = (score_r == WIN);
            end else begin
              nxt          = SERVE;
              ball_reset_d = 1'b1;
            end
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end
      end
      OVER: begin
        if (start_rise) begin
          nxt          = SERVE;
          cnt_d        = 8'd0;
          ball_reset_d = 1'b1;
          serve_dir_d  = 1'b1;
          score_l_d    = 4'd0;
          score_r_d    = 4'd0;
        end
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-sequencing controller for the two-player ping-pong display. Owns the match state machine: waits for start, serves the ball, enables paddle and ball motion, scores misses, pauses on request, and declares a winner. Sits between the player inputs/frame strobe and the ping-pong datapath, gating its motion updates and requesting ball re-centring.

## Interface
- POINTS_TO_WIN, 9, score that ends the match; legal range 1–15.
- SERVE_DELAY, 60, frame ticks between ball re-centre and motion start; 0 is treated as 1.
- POINT_DELAY, 90, frame ticks of freeze after a point before the next serve; 0 is treated as 1.
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- frame_tick  input  1  one-cycle pulse per video frame; the datapath's motion-update strobe.
- start  input  1  level from the start/pause button, already debounced; rising edge detected internally.
- miss_l  input  1  one-cycle pulse: ball reached the left wall (left player missed).
- miss_r  input  1  one-cycle pulse: ball reached the right wall (right player missed).
- play_en  output  1  datapath may move ball and bars.
- ball_reset  output  1  one-cycle pulse: datapath reloads the ball at centre with horizontal direction serve_dir.
- serve_dir  output  1  1 = serve toward the right player, 0 = toward the left.
- score_l  output  4  left player score, binary.
- score_r  output  4  right player score, binary.
- game_over  output  1  match finished.
- winner  output  1  valid when game_over: 0 = left, 1 = right.
- state  output  3  current FSM state, for debug/overlay.

## Operation
- States (encoding): IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, OVER=5. Codes 6–7 return to IDLE on the next cycle.
- start_rise = start & ~start_q, where start_q is start registered every cycle (reset to 0).
- IDLE: play_en=0. start_rise → SERVE; clear both scores, serve_dir=1.
- SERVE: ball_reset high during the first cycle in state only; frame counter cleared on entry, increments on frame_tick; after SERVE_DELAY ticks → PLAY.
- PLAY: play_en=1. Priority per cycle:
  - miss_l & miss_r together: no score, serve_dir unchanged, → POINT.
  - miss_l: score_r+1, serve_dir=0, → POINT.
  - miss_r: score_l+1, serve_dir=1, → POINT.
  - start_rise: → PAUSE.
  - A miss wins over start_rise in the same cycle.
- PAUSE: play_en=0; miss pulses ignored; start_rise → PLAY.
- POINT: play_en=0; counter cleared on entry, counts frame_tick; after POINT_DELAY ticks: if score_l or score_r == POINTS_TO_WIN → OVER, else → SERVE.
- OVER: game_over=1, winner=1 if score_r == POINTS_TO_WIN else 0; scores held. start_rise → SERVE with scores cleared, game_over cleared, serve_dir=1.
- Scores saturate at POINTS_TO_WIN; never wrap.
- Frame counter 8 bits; delays above 255 are not supported.
- miss and frame_tick inputs are ignored outside the states that list them.

## Timing
- All outputs registered; each changes on the clk edge that enters the new state.
- Reset values: state=IDLE, play_en=0, ball_reset=0, serve_dir=1, score_l=0, score_r=0, game_over=0, winner=0, start_q=0, counter=0.
- Reset asserted mid-match returns to IDLE on the next edge, regardless of state; scores cleared.
- start edge to state change: 1 cycle after the cycle in which start first reads high.
- Miss pulse in PLAY: score updates and play_en falls on the following edge (1-cycle latency).
- SERVE exit: the edge after the cycle carrying the SERVE_DELAY-th frame_tick; play_en rises on that edge.
- frame_tick coincident with the entry edge into SERVE/POINT is not counted.
- ball_reset is exactly one cycle wide per SERVE entry, including re-entry after OVER.

## Test plan
- Reset then start rise (params 3/2/3) → SERVE next cycle, ball_reset one cycle, scores 0/0; after 2 frame_ticks → PLAY, play_en=1.
- In PLAY pulse miss_r → score_l=1, serve_dir=1, POINT; after 3 ticks → SERVE with a new ball_reset pulse.
- Three miss_l points → score_r=3, POINT then OVER, game_over=1, winner=1; further miss pulses leave scores unchanged.
- miss_l and miss_r in the same cycle → scores unchanged, serve_dir unchanged, → POINT; miss_l with start_rise → scores, no PAUSE.
- start_rise in PLAY → PAUSE, play_en=0; miss_l in PAUSE ignored; second start_rise → PLAY.
- Reset asserted in POINT with score 2:1 → IDLE, scores 0/0, all outputs at reset values next cycle; OVER + start_rise → SERVE, scores cleared, game_over=0.
